alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl.sv | 148 ++++++++++++++
 tb/tb_alu_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// alu_ctrl: 5-byte command framer driving a registered ALU, result via valid/ready.
// ALU_CTRL_FRAME_TIMEOUT_EN enables the mid-frame idle timeout (TIMEOUT_CYCLES).
module alu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_fun,
  input  logic [15:0] alu_out,
  input  logic [3:0]  alu_flags,
  output logic [15:0] res_data,
  output logic [3:0]  res_flags,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        err,
  output logic [7:0]  ops_done
);

  typedef enum logic [2:0] {
    IDLE,
    RX_AH,
    RX_AL,
    RX_BH,
    RX_BL,
    EXEC,
    WAIT,
    RESP
  } state_t;

  state_t state;

  logic acc;
  logic op_ok;

  assign acc   = in_valid & in_ready;
  assign op_ok = (in_data[7:4] == 4'h0) &&
                 (in_data[3:0] != 4'hF);

`ifdef ALU_CTRL_FRAME_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] idle_cnt;
  logic             in_rx;

  assign in_rx = (state == RX_AH) || (state == RX_AL) ||
                 (state == RX_BH) || (state == RX_BL);
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      alu_a     <= 16'h0000;
      alu_b     <= 16'h0000;
      alu_fun   <= 4'h0;
      res_data  <= 16'h0000;
      res_flags <= 4'h0;
      res_valid <= 1'b0;
      err       <= 1'b0;
      ops_done  <= 8'h00;
`ifdef ALU_CTRL_FRAME_TIMEOUT_EN
      idle_cnt  <= '0;
`endif
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (acc) begin
            if (op_ok) begin
              alu_fun <= in_data[3:0];
              state   <= RX_AH;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RX_AH: begin
          if (acc) begin
            alu_a[15:8] <= in_data;
            state       <= RX_AL;
          end
        end
        RX_AL: begin
          if (acc) begin
            alu_a[7:0] <= in_data;
            state      <= RX_BH;
          end
        end
        RX_BH: begin
          if (acc) begin
            alu_b[15:8] <= in_data;
            state       <= RX_BL;
          end
        end
        RX_BL: begin
          if (acc) begin
            alu_b[7:0] <= in_data;
            in_ready   <= 1'b0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          state <= WAIT;
        end
        WAIT: begin
          res_data  <= alu_out;
          res_flags <= alu_flags;
          res_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            ops_done  <= ops_done + 8'd1;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
`ifdef ALU_CTRL_FRAME_TIMEOUT_EN
      // Abort overrides the case above; alu_* keep what was accepted.
      if (!in_rx || in_valid) begin
        idle_cnt <= '0;
      end else if (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        idle_cnt <= '0;
        err      <= 1'b1;
        state    <= IDLE;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: randomized frames against a reference model, scoreboard checked.
// Includes a simple registered ALU model as the downstream environment.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_fun;
  logic [15:0] alu_out = 16'h0000;
  logic [3:0]  alu_flags;
  logic [15:0] res_data;
  logic [3:0]  res_flags;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic        err;
  logic [7:0]  ops_done;

  alu_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .res_data(res_data), .res_flags(res_flags),
    .res_valid(res_valid), .res_ready(res_ready),
    .err(err), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: function codes grouped by category of 4
  function automatic logic [15:0] alu_f(
    input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    int s;
    case (f)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return 16'((32'(a) * 32'(b)) & 32'hFFFF);
      4'h3: return (b == 0) ? 16'hFFFF : a / b;
      4'h4: return a & b;
      4'h5: return a | b;
      4'h6: return a ^ b;
      4'h7: return ~a;
      4'h8: return {15'd0, a < b};
      4'h9: return {15'd0, $signed(a) < $signed(b)};
      4'hA: return {15'd0, a == b};
      4'hB: return {15'd0, a != b};
      4'hC: return a << b[3:0];
      4'hD: begin s = int'(b[3:0]) + 1; return a >> s; end
      4'hE: return (a << b[3:0]) | (a >> (16 - int'(b[3:0])));
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [3:0] flag_f(input logic [3:0] f);
    if (f < 4) return 4'b1000;
    if (f < 8) return 4'b0100;
    if (f < 12) return 4'b0010;
    return 4'b0001;
  endfunction

  always @(posedge clk) alu_out <= alu_f(alu_fun, alu_a, alu_b);
  assign alu_flags = flag_f(alu_fun);

  typedef struct {
    logic [15:0] d;
    logic [3:0]  f;
    int          edge_n;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int last_edge = 0;
  int rr_mode = 0;
  logic [7:0] exp_ops = 8'h00;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // res_ready driver: 0 = always ready, 1 = random, 2 = stalled
  always @(posedge clk) begin
    #2;
    case (rr_mode)
      0: res_ready = 1'b1;
      1: res_ready = ($urandom_range(0, 2) != 0);
      default: res_ready = 1'b0;
    endcase
  end

  // Monitor: pops on every result handshake
  logic        prev_valid = 1'b0;
  logic [15:0] prev_data;
  logic [3:0]  prev_flags;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (res_valid) begin
        check("in_ready_in_resp", in_ready, 0);
        if (prev_valid) begin
          check("hold_data", res_data, prev_data);
          check("hold_flags", res_flags, prev_flags);
        end else if (sb.size() == 0) begin
          check("unexpected_res", 1, 0);
        end else begin
          check("latency", cyc, sb[0].edge_n + 2);
        end
      end
      if (res_valid && res_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("res_data", res_data, e.d);
        check("res_flags", res_flags, e.f);
        check("ops_before", ops_done, exp_ops);
        exp_ops = exp_ops + 8'd1;
        prev_valid = 1'b0;
      end else begin
        prev_valid = res_valid;
      end
      prev_data  = res_data;
      prev_flags = res_flags;
    end
  end

  function automatic bit op_valid(input logic [7:0] op);
    return (op[7:4] == 4'h0) && (op[3:0] != 4'hF);
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit is_op);
    int g;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    last_edge = cyc;
    check("err", err, (is_op && !op_valid(b)) ? 1 : 0);
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [15:0] a,
                            input logic [15:0] b);
    exp_t e;
    send_byte(op, 1);
    if (!op_valid(op)) return;
    send_byte(a[15:8], 0);
    send_byte(a[7:0], 0);
    send_byte(b[15:8], 0);
    send_byte(b[7:0], 0);
    e.d = alu_f(op[3:0], a, b);
    e.f = flag_f(op[3:0]);
    e.edge_n = last_edge;
    sb.push_back(e);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || res_valid) && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_alu"}, {alu_a, alu_b}, 0);
    check({tag, "_fun_flags"}, {alu_fun, res_flags}, 0);
    check({tag, "_res"}, {res_data, res_valid, err}, 0);
    check({tag, "_ops"}, ops_done, 0);
  endtask

  initial begin
    logic [7:0] op;
    logic [15:0] a_s, b_s;
    logic [3:0] f_s;
    bit seen;
    int g;

    #1;
    check_reset_vals("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Add example
    send_frame(8'h00, 16'h0005, 16'h0003);
    drain();
    check("ops_after_add", ops_done, 1);

    // Rejected opcodes leave everything alone
    a_s = alu_a; b_s = alu_b; f_s = alu_fun;
    send_byte(8'h0F, 1);
    check("ready_after_bad", in_ready, 1);
    send_byte(8'h2F, 1);
    check("ready_after_bad2", in_ready, 1);
    check("alu_unchanged", {alu_a, alu_b, alu_fun}, {a_s, b_s, f_s});
    send_frame(8'h0A, 16'h1234, 16'h1234);
    drain();

    // Stalled result channel
    rr_mode = 2;
    send_frame(8'h02, 16'h0100, 16'h0300);
    g = 0;
    while (!res_valid && g < 50) begin @(negedge clk); g++; end
    check("stall_valid", res_valid, 1);
    op = ops_done;
    repeat (10) @(negedge clk);
    check("stall_still_valid", res_valid, 1);
    check("stall_ops", ops_done, op);
    rr_mode = 0;
    drain();
    @(negedge clk);
    check("idle_after_hs", in_ready, 1);

    // Mid-frame reset
    send_byte(8'h01, 1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    exp_ops = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h0D, 16'h8000, 16'h0000);
    drain();

    // Idle mid-frame
    send_byte(8'h00, 1);
    send_byte(8'h12, 0);
    seen = 0;
`ifdef ALU_CTRL_FRAME_TIMEOUT_EN
    g = 0;
    while (!seen && g < 300) begin
      @(negedge clk);
      g++;
      if (err) begin
        seen = 1;
        check("timeout_cycle", cyc, last_edge + 255);
      end
    end
    check("timeout_err", seen, 1);
    send_frame(8'h01, 16'h0009, 16'h0004);
`else
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (err || !in_ready) seen = 1;
    end
    check("no_timeout", seen, 0);
    send_byte(8'h34, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    begin
      exp_t e;
      e.d = alu_f(4'h0, 16'h1234, 16'h0001);
      e.f = flag_f(4'h0);
      e.edge_n = last_edge;
      sb.push_back(e);
    end
`endif
    drain();

    // 256+ random back-to-back frames, random backpressure
    rr_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) op = 8'($urandom);
      else op = 8'($urandom_range(0, 14));
      send_frame(op, 16'($urandom), 16'($urandom));
    end
    rr_mode = 0;
    drain();
    check("ops_wrap", ops_done, exp_ops);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
